// File: rtl/sdram_cpu_bridge_if.sv
// sdram_cpu_bridge_if: 65C02 bus cycle signals plus the native SDRAM controller request port.
// slave = the bridge, master = the CPU/decoder and controller environment driving it.
interface sdram_cpu_bridge_if #(
    parameter int ADDR_WIDTH = 24,
    parameter int SDR_DW = 16
);
    logic                    i_cpu_phi2;
    logic                    i_cs;
    logic                    i_cpu_rwb;
    logic [ADDR_WIDTH-1:0]   i_addr;
    logic [7:0]              i_cpu_data;
    logic [7:0]              o_cpu_data;
    logic                    o_cpu_rdy;
    logic                    o_sdr_we;
    logic                    o_sdr_re;
    logic [ADDR_WIDTH-2:0]   o_sdr_addr;
    logic [SDR_DW-1:0]       o_sdr_din;
    logic [1:0]              o_sdr_dm;
    logic                    i_sdr_busy;
    logic                    i_sdr_wr_ack;
    logic                    i_sdr_rd_valid;
    logic [SDR_DW-1:0]       i_sdr_dout;
    logic                    o_timeout;
    modport slave (
        input  i_cpu_phi2, i_cs, i_cpu_rwb, i_addr, i_cpu_data,
        input  i_sdr_busy, i_sdr_wr_ack, i_sdr_rd_valid, i_sdr_dout,
        output o_cpu_data, o_cpu_rdy, o_sdr_we, o_sdr_re, o_sdr_addr, o_sdr_din, o_sdr_dm, o_timeout
    );
    modport master (
        output i_cpu_phi2, i_cs, i_cpu_rwb, i_addr, i_cpu_data,
        output i_sdr_busy, i_sdr_wr_ack, i_sdr_rd_valid, i_sdr_dout,
        input  o_cpu_data, o_cpu_rdy, o_sdr_we, o_sdr_re, o_sdr_addr, o_sdr_din, o_sdr_dm, o_timeout
    );
endinterface

// File: rtl/sdram_cpu_bridge.sv
// sdram_cpu_bridge: turns one 65C02 bus cycle into one SDRAM word request, stalling the CPU via RDY.
// Byte lanes are selected by addr[0] through DQM; a missing ack aborts after TIMEOUT_CYC cycles.
module sdram_cpu_bridge #(
    parameter int ADDR_WIDTH = 24,
    parameter int SDR_DW = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             i_sysclk,
    input  logic             i_resb,
    sdram_cpu_bridge_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    state_t        state;
    logic [1:0]    phi2_sync;
    logic          phi2_q;
    logic          lane;
    logic          rwb;
    logic [CW-1:0] cnt;
    logic          rise;
    logic          fall;
    logic          ack;
    logic          expired;
    assign rise    = phi2_sync[1] & ~phi2_q;
    assign fall    = ~phi2_sync[1] & phi2_q;
    assign ack     = rwb ? bus.i_sdr_rd_valid : bus.i_sdr_wr_ack;
    assign expired = cnt == CW'(TIMEOUT_CYC);
    always_ff @(posedge i_sysclk) begin
        if (!i_resb) begin
            state          <= IDLE;
            phi2_sync      <= '0;
            phi2_q         <= 1'b0;
            lane           <= 1'b0;
            rwb            <= 1'b0;
            cnt            <= '0;
            bus.o_cpu_rdy  <= 1'b1;
            bus.o_sdr_we   <= 1'b0;
            bus.o_sdr_re   <= 1'b0;
            bus.o_cpu_data <= 8'h00;
            bus.o_timeout  <= 1'b0;
            bus.o_sdr_addr <= '0;
            bus.o_sdr_din  <= '0;
            bus.o_sdr_dm   <= 2'b11;
        end else begin
            phi2_sync    <= {phi2_sync[0], bus.i_cpu_phi2};
            phi2_q       <= phi2_sync[1];
            bus.o_sdr_we <= 1'b0;
            bus.o_sdr_re <= 1'b0;
            case (state)
                IDLE: if (rise && bus.i_cs) begin
                    bus.o_sdr_addr <= bus.i_addr[ADDR_WIDTH-1:1];
                    bus.o_sdr_din  <= {(SDR_DW/8){bus.i_cpu_data}};
                    bus.o_sdr_dm   <= bus.i_addr[0] ? 2'b01 : 2'b10;
                    lane           <= bus.i_addr[0];
                    rwb            <= bus.i_cpu_rwb;
                    cnt            <= '0;
                    bus.o_cpu_rdy  <= 1'b0;
                    state          <= ISSUE;
                end
                ISSUE: if (!bus.i_sdr_busy) begin
                    bus.o_sdr_re <= rwb;
                    bus.o_sdr_we <= ~rwb;
                    state        <= WAIT;
                end
                WAIT: begin
                    cnt <= expired ? cnt : cnt + 1'b1;
                    // an ack in the expiry cycle still completes normally
                    if (ack) begin
                        bus.o_cpu_data <= rwb ? (lane ? bus.i_sdr_dout[15:8] : bus.i_sdr_dout[7:0]) : bus.o_cpu_data;
                        bus.o_cpu_rdy  <= 1'b1;
                        state          <= DONE;
                    end else if (expired) begin
                        bus.o_timeout  <= 1'b1;
                        bus.o_cpu_data <= rwb ? 8'hFF : bus.o_cpu_data;
                        bus.o_cpu_rdy  <= 1'b1;
                        state          <= DONE;
                    end
                end
                DONE: if (fall) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// tb_sdram_cpu_bridge: random 65C02 cycles against a byte-memory reference model with a
// scoreboard monitor checking SDRAM requests and CPU completions.
module tb_sdram_cpu_bridge;
    localparam int TO = 255;
    localparam int PH = 8;
    typedef struct packed {
        logic        re;
        logic        we;
        logic [22:0] addr;
        logic [15:0] din;
        logic [1:0]  dm;
    } req_t;
    typedef struct packed {
        logic       rd;
        logic [7:0] data;
        logic       to;
        logic       sticky;
    } rsp_t;
    logic clk = 1'b0;
    logic resb = 1'b0;
    always #5 clk = ~clk;
    sdram_cpu_bridge_if bus();
    sdram_cpu_bridge #(.ADDR_WIDTH(24), .SDR_DW(16), .TIMEOUT_CYC(TO)) dut (
        .i_sysclk(clk),
        .i_resb(resb),
        .bus(bus)
    );
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int strobe_t = 0;
    int ctl_lat = 0;
    bit ctl_drop = 0;
    bit ctl_auto = 1;
    bit force_busy = 0;
    bit rand_busy = 0;
    bit spur_en = 0;
    bit man_valid = 0;
    logic [15:0] man_dout = 16'h0;
    bit sticky = 0;
    req_t req_q[$];
    rsp_t rsp_q[$];
    logic [7:0]  ref_mem [logic [23:0]];
    logic [15:0] wmem [logic [22:0]];
    function automatic logic [7:0] dflt(input logic [23:0] a);
        return a[7:0] ^ a[23:16] ^ 8'h5A;
    endfunction
    function automatic logic [7:0] ref_rd(input logic [23:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction
    function automatic logic [15:0] mem_rd(input logic [22:0] w);
        return wmem.exists(w) ? wmem[w] : {dflt({w, 1'b1}), dflt({w, 1'b0})};
    endfunction
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    // One CPU bus cycle, stretched by RDY; RDY is sampled where the bridge sees phi2 fall.
    task automatic cpu_cycle(input bit cs, input bit rd, input logic [23:0] a, input logic [7:0] d,
                             input int lat, input bit drop);
        bit done;
        bit to;
        int n;
        logic [7:0] ed;
        @(negedge clk);
        bus.i_cs = cs;
        bus.i_cpu_rwb = rd;
        bus.i_addr = a;
        bus.i_cpu_data = d;
        ctl_lat = lat;
        ctl_drop = drop;
        if (cs) begin
            to = drop || lat > TO;
            req_q.push_back('{re: rd, we: !rd, addr: a[23:1], din: {d, d}, dm: a[0] ? 2'b01 : 2'b10});
            ed = 8'h00;
            if (rd) ed = to ? 8'hFF : ref_rd(a);
            else if (!drop) ref_mem[a] = d;
            sticky = sticky | to;
            rsp_q.push_back('{rd: rd, data: ed, to: to, sticky: sticky});
        end
        done = 0;
        n = 0;
        while (!done) begin
            bus.i_cpu_phi2 = 1'b1;
            repeat (PH) @(negedge clk);
            bus.i_cpu_phi2 = 1'b0;
            repeat (2) @(negedge clk);
            if (!cs) chk("cs0_rdy", bus.o_cpu_rdy, 1);
            done = bus.o_cpu_rdy || !cs;
            repeat (PH - 2) @(negedge clk);
            n++;
            if (!done && n > 40) begin
                total++;
                bad++;
                $display("FAIL cpu_stall_bound: rdy=%0b after %0d phi2 periods, want 1", bus.o_cpu_rdy, n);
                done = 1;
            end
        end
        bus.i_cs = 1'b0;
    endtask
    // SDRAM controller model: word store with DQM, programmable ack latency, busy and spurious acks.
    initial begin
        bit pend;
        bit p_rd;
        bit p_drop;
        int p_cnt;
        logic [22:0] p_addr;
        logic [15:0] w;
        pend = 0;
        p_rd = 0;
        p_drop = 0;
        p_cnt = 0;
        p_addr = '0;
        bus.i_sdr_busy = 1'b0;
        bus.i_sdr_wr_ack = 1'b0;
        bus.i_sdr_rd_valid = 1'b0;
        bus.i_sdr_dout = 16'h0;
        forever begin
            @(negedge clk);
            if (!resb) pend = 0;
            else if (bus.o_sdr_we || bus.o_sdr_re) begin
                pend = 1;
                p_rd = bus.o_sdr_re;
                p_addr = bus.o_sdr_addr;
                p_cnt = ctl_lat;
                p_drop = ctl_drop;
                if (bus.o_sdr_we && !ctl_drop) begin
                    w = mem_rd(bus.o_sdr_addr);
                    if (!bus.o_sdr_dm[0]) w[7:0] = bus.o_sdr_din[7:0];
                    if (!bus.o_sdr_dm[1]) w[15:8] = bus.o_sdr_din[15:8];
                    wmem[bus.o_sdr_addr] = w;
                end
            end
            #1;
            bus.i_sdr_wr_ack = 1'b0;
            bus.i_sdr_rd_valid = 1'b0;
            bus.i_sdr_dout = 16'($urandom);
            bus.i_sdr_busy = force_busy | (rand_busy && $urandom_range(0, 3) == 0);
            if (!ctl_auto) begin
                bus.i_sdr_rd_valid = man_valid;
                if (man_valid) bus.i_sdr_dout = man_dout;
            end else if (pend && !p_drop) begin
                if (p_cnt == 0) begin
                    pend = 0;
                    if (p_rd) begin
                        bus.i_sdr_rd_valid = 1'b1;
                        bus.i_sdr_dout = mem_rd(p_addr);
                    end else bus.i_sdr_wr_ack = 1'b1;
                end else p_cnt--;
            end else if (!pend && spur_en && $urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 1) bus.i_sdr_wr_ack = 1'b1;
                else bus.i_sdr_rd_valid = 1'b1;
            end
        end
    end
    // Scoreboard monitor: requests on each strobe, completions on each RDY rise.
    initial begin
        bit prev_rdy;
        bit prev_stb;
        bit stb;
        req_t got;
        rsp_t e;
        prev_rdy = 1;
        prev_stb = 0;
        forever begin
            @(negedge clk);
            cyc++;
            stb = bus.o_sdr_we | bus.o_sdr_re;
            if (!resb) begin
                prev_rdy = bus.o_cpu_rdy;
                prev_stb = 0;
                continue;
            end
            if (stb) begin
                strobe_cnt++;
                strobe_t = cyc;
                chk("busy_at_strobe", bus.i_sdr_busy, 0);
                chk("strobe_width", prev_stb, 0);
                got = '{re: bus.o_sdr_re, we: bus.o_sdr_we, addr: bus.o_sdr_addr, din: bus.o_sdr_din, dm: bus.o_sdr_dm};
                if (req_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_strobe: got request %0h, want none", got);
                end else chk("request", got, req_q.pop_front());
            end
            if (bus.o_cpu_rdy && !prev_rdy) begin
                if (rsp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rdy: got rdy rise, want none");
                end else begin
                    e = rsp_q.pop_front();
                    chk("ack_at_rdy", bus.i_sdr_wr_ack | bus.i_sdr_rd_valid, !e.to);
                    if (e.rd) chk("rd_data", bus.o_cpu_data, e.data);
                    chk("timeout_flag", bus.o_timeout, e.sticky);
                    if (e.to) chk("to_latency", (cyc - strobe_t >= TO) && (cyc - strobe_t <= TO + 2), 1);
                end
            end
            prev_rdy = bus.o_cpu_rdy;
            prev_stb = stb;
        end
    end
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, want test done");
        $fatal(1, "watchdog");
    end
    initial begin
        int n0;
        int n;
        bit cs;
        bit rd;
        bit drop;
        int r;
        int lat;
        logic [23:0] a;
        bus.i_cpu_phi2 = 1'b0;
        bus.i_cs = 1'b0;
        bus.i_cpu_rwb = 1'b1;
        bus.i_addr = '0;
        bus.i_cpu_data = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_rdy", bus.o_cpu_rdy, 1);
        chk("rst_we", bus.o_sdr_we, 0);
        chk("rst_re", bus.o_sdr_re, 0);
        chk("rst_data", bus.o_cpu_data, 0);
        chk("rst_timeout", bus.o_timeout, 0);
        resb = 1'b1;
        repeat (4) @(negedge clk);
        cpu_cycle(1, 0, 24'h000101, 8'hA5, 5, 0);
        wmem[23'h000080] = 16'h1234;
        ref_mem[24'h000100] = 8'h34;
        ref_mem[24'h000101] = 8'h12;
        cpu_cycle(1, 1, 24'h000100, 8'h00, 3, 0);
        cpu_cycle(1, 1, 24'h000101, 8'h00, 0, 0);
        n0 = strobe_cnt;
        force_busy = 1;
        fork
            cpu_cycle(1, 1, 24'h000100, 8'h3C, 2, 0);
            begin
                repeat (24) @(negedge clk);
                force_busy = 0;
            end
        join
        chk("busy_single_req", strobe_cnt - n0, 1);
        n0 = strobe_cnt;
        repeat (3) cpu_cycle(0, 1, 24'h000100, 8'h00, 0, 0);
        chk("cs0_no_req", strobe_cnt - n0, 0);
        n0 = strobe_cnt;
        cpu_cycle(1, 0, 24'h000042, 8'h77, 40, 0);
        chk("stall_single_req", strobe_cnt - n0, 1);
        cpu_cycle(1, 1, 24'h000042, 8'h00, TO, 0);
        cpu_cycle(1, 1, 24'h000043, 8'h00, TO + 1, 0);
        rand_busy = 1;
        spur_en = 1;
        repeat (150) begin
            cs = $urandom_range(0, 7) != 0;
            rd = $urandom_range(0, 1) == 1;
            a = (24'($urandom_range(0, 31)) << 19) | 24'($urandom_range(0, 31));
            r = $urandom_range(0, 99);
            drop = r < 2;
            lat = r < 4 ? TO : r < 6 ? TO + 1 : $urandom_range(0, 12);
            cpu_cycle(cs, rd, a, 8'($urandom), lat, drop);
        end
        rand_busy = 0;
        spur_en = 0;
        cpu_cycle(1, 1, 24'h000010, 8'h00, 0, 1);
        cpu_cycle(1, 0, 24'h000011, 8'hC3, 1, 0);
        cpu_cycle(1, 1, 24'h000011, 8'h00, 4, 0);
        ctl_drop = 1;
        req_q.push_back('{re: 1'b1, we: 1'b0, addr: 23'h000019, din: 16'h0000, dm: 2'b10});
        @(negedge clk);
        bus.i_cs = 1'b1;
        bus.i_cpu_rwb = 1'b1;
        bus.i_addr = 24'h000032;
        bus.i_cpu_data = 8'h00;
        bus.i_cpu_phi2 = 1'b1;
        n = 0;
        while (!(bus.o_sdr_we || bus.o_sdr_re) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_strobe_seen", n < 20, 1);
        repeat (4) @(negedge clk);
        bus.i_cpu_phi2 = 1'b0;
        bus.i_cs = 1'b0;
        resb = 1'b0;
        @(negedge clk);
        chk("t6_rdy", bus.o_cpu_rdy, 1);
        chk("t6_we", bus.o_sdr_we, 0);
        chk("t6_re", bus.o_sdr_re, 0);
        chk("t6_timeout", bus.o_timeout, 0);
        chk("t6_data", bus.o_cpu_data, 0);
        repeat (3) @(negedge clk);
        resb = 1'b1;
        sticky = 0;
        ctl_auto = 0;
        repeat (2) @(negedge clk);
        man_dout = 16'hBEEF;
        man_valid = 1;
        @(negedge clk);
        man_valid = 0;
        repeat (4) @(negedge clk);
        chk("t6_late_ack_data", bus.o_cpu_data, 0);
        chk("t6_late_ack_rdy", bus.o_cpu_rdy, 1);
        chk("req_q_empty", req_q.size(), 0);
        chk("rsp_q_empty", rsp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
